// File: rtl/ch_merge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ch_merge_pkg
// Description : Shared types and helpers for the N-channel merge/ReLU stage:
//               FSM state encoding, read tag layout, accumulator sizing and
//               the saturate/ReLU output function.
// Revision    : 1.0 - initial release
// ============================================================================
package ch_merge_pkg;

    // Width of the pixel index carried in a read tag (bounds MAP to 64K pixels)
    localparam int c_TAG_PIX_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Travels alongside each read so the accumulator knows how to treat the word
    typedef struct packed {
        logic                   first;
        logic                   last;
        logic [c_TAG_PIX_W-1:0] pixel;
    } tag_t;

    // Enough headroom to sum MAX_CHANNELS words plus a bias without wrapping
    function automatic int acc_width(input int data_w, input int max_ch);
        return data_w + $clog2(max_ch) + 1;
    endfunction

    // Clamp to the signed data_w range, then optionally zero negatives
    function automatic logic [63:0] sat_relu(input logic signed [63:0] value,
                                             input int                 data_w,
                                             input logic               relu);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (value > hi) begin
            r = hi;
        end else if (value < lo) begin
            r = lo;
        end else begin
            r = value;
        end
        if (relu && (r < 64'sd0)) begin
            r = 64'sd0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/read_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : read_tag_pipe
// Description : DEPTH-stage register pipe carrying a read tag and valid bit so
//               the tag lines up with data returned by the source memory.
// Revision    : 1.0 - initial release
// ============================================================================
module read_tag_pipe
    import ch_merge_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    input  tag_t i_tag,
    output logic o_valid,
    output tag_t o_tag,
    output logic o_busy
);

    logic [DEPTH-1:0] r_valid;
    tag_t             r_tag [DEPTH];

    // Shift tags one stage per cycle; reset empties every stage at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_tag[0]   <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_tag   = r_tag[DEPTH-1];
    assign o_busy  = |r_valid;

endmodule
`default_nettype wire

// File: rtl/channel_merge_relu.sv
`default_nettype none
// ============================================================================
// Module      : channel_merge_relu
// Description : Reads C per-channel conv maps pixel-major, sums each pixel's
//               channels with a bias, saturates, optionally applies ReLU and
//               writes the merged map. Pulses merge_done when finished.
// Revision    : 1.0 - initial release
// ============================================================================
module channel_merge_relu
    import ch_merge_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int MAP_WIDTH    = 24,
    parameter int MAP_HEIGHT   = 24,
    parameter int MAX_CHANNELS = 8,
    parameter int READ_LATENCY = 1,
    parameter int BASE_IN      = 0,
    parameter int BASE_OUT     = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              run,
    input  logic [$clog2(MAX_CHANNELS):0]     num_channels,
    input  logic                              relu_en,
    input  logic [DATA_WIDTH-1:0]             bias_in,
    input  logic [DATA_WIDTH-1:0]             data_in,
    output logic [ADDR_WIDTH-1:0]             read_address_out,
    output logic [DATA_WIDTH-1:0]             result_out,
    output logic [ADDR_WIDTH-1:0]             write_address_out,
    output logic                              we_out,
    output logic                              busy,
    output logic                              merge_done
);

    localparam int c_MAP   = MAP_WIDTH * MAP_HEIGHT;
    localparam int c_CH_W  = $clog2(MAX_CHANNELS) + 1;
    localparam int c_ACC_W = acc_width(DATA_WIDTH, MAX_CHANNELS);
    localparam logic [c_TAG_PIX_W-1:0] c_LAST_PIX = c_TAG_PIX_W'(c_MAP - 1);

    state_t                  r_state;
    logic [c_CH_W-1:0]       r_ch;
    logic [c_CH_W-1:0]       r_last_ch;
    logic [c_TAG_PIX_W-1:0]  r_pix;
    logic                    r_relu;
    logic [DATA_WIDTH-1:0]   r_bias;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic                    r_iss_valid;
    tag_t                    r_iss_tag;
    logic                    r_busy;
    logic                    r_done;

    logic signed [c_ACC_W-1:0] r_acc;
    logic [DATA_WIDTH-1:0]     r_result;
    logic [ADDR_WIDTH-1:0]     r_wr_addr;
    logic                      r_we;

    logic [c_CH_W-1:0]         w_eff_ch;
    logic                      w_accept;
    logic                      w_last_ch;
    logic [ADDR_WIDTH-1:0]     w_iss_addr;
    logic                      w_out_valid;
    tag_t                      w_out_tag;
    logic                      w_pipe_any;
    logic                      w_pipe_busy;
    logic signed [c_ACC_W-1:0] w_data_x;
    logic signed [c_ACC_W-1:0] w_bias_x;
    logic signed [c_ACC_W-1:0] w_sum;
    logic [DATA_WIDTH-1:0]     w_result;

    // Clamp the requested channel count into 1..MAX_CHANNELS
    always_comb begin
        w_eff_ch = num_channels;
        if (num_channels == '0) begin
            w_eff_ch = c_CH_W'(1);
        end else if (num_channels > c_CH_W'(MAX_CHANNELS)) begin
            w_eff_ch = c_CH_W'(MAX_CHANNELS);
        end
    end

    // DONE accepts a new run so back-to-back merges have no idle gap
    assign w_accept    = run && ((r_state == IDLE) || (r_state == DONE));
    assign w_last_ch   = (r_ch == r_last_ch);
    assign w_iss_addr  = ADDR_WIDTH'(BASE_IN) + ADDR_WIDTH'(r_ch) * ADDR_WIDTH'(c_MAP)
                       + ADDR_WIDTH'(r_pix);
    assign w_pipe_busy = r_iss_valid | w_pipe_any;

    // Control FSM: issues one read per cycle, pixel outer / channel inner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ch        <= '0;
            r_last_ch   <= '0;
            r_pix       <= '0;
            r_relu      <= 1'b0;
            r_bias      <= '0;
            r_rd_addr   <= '0;
            r_iss_valid <= 1'b0;
            r_iss_tag   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_iss_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_last_ch       <= w_eff_ch - c_CH_W'(1);
                        r_relu          <= relu_en;
                        r_bias          <= bias_in;
                        r_busy          <= 1'b1;
                        r_rd_addr       <= ADDR_WIDTH'(BASE_IN);
                        r_iss_valid     <= 1'b1;
                        r_iss_tag.first <= 1'b1;
                        r_iss_tag.last  <= (w_eff_ch == c_CH_W'(1));
                        r_iss_tag.pixel <= '0;
                        if (w_eff_ch == c_CH_W'(1)) begin
                            r_ch  <= '0;
                            r_pix <= c_TAG_PIX_W'(1);
                        end else begin
                            r_ch  <= c_CH_W'(1);
                            r_pix <= '0;
                        end
                        // A single-read merge has nothing left to issue
                        if ((w_eff_ch == c_CH_W'(1)) && (c_MAP == 1)) begin
                            r_state <= DRAIN;
                        end else begin
                            r_state <= READ;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                READ: begin
                    r_rd_addr       <= w_iss_addr;
                    r_iss_valid     <= 1'b1;
                    r_iss_tag.first <= (r_ch == '0);
                    r_iss_tag.last  <= w_last_ch;
                    r_iss_tag.pixel <= r_pix;
                    if (w_last_ch) begin
                        r_ch  <= '0;
                        r_pix <= r_pix + c_TAG_PIX_W'(1);
                        if (r_pix == c_LAST_PIX) begin
                            r_state <= DRAIN;
                        end
                    end else begin
                        r_ch <= r_ch + c_CH_W'(1);
                    end
                end
                DRAIN: begin
                    // Empty pipe means the final write is already on the outputs
                    if (!w_pipe_busy) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    read_tag_pipe #(
        .DEPTH   (READ_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (reset),
        .i_valid (r_iss_valid),
        .i_tag   (r_iss_tag),
        .o_valid (w_out_valid),
        .o_tag   (w_out_tag),
        .o_busy  (w_pipe_any)
    );

    assign w_data_x = {{(c_ACC_W-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
    assign w_bias_x = {{(c_ACC_W-DATA_WIDTH){r_bias[DATA_WIDTH-1]}}, r_bias};
    assign w_sum    = w_out_tag.first ? (w_bias_x + w_data_x) : (r_acc + w_data_x);
    assign w_result = DATA_WIDTH'(sat_relu(64'(w_sum), DATA_WIDTH, r_relu));

    // Accumulate each pixel's channels and register a write on its last channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc     <= '0;
            r_result  <= '0;
            r_wr_addr <= '0;
            r_we      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_out_valid) begin
                r_acc <= w_sum;
                if (w_out_tag.last) begin
                    r_result  <= w_result;
                    r_wr_addr <= ADDR_WIDTH'(BASE_OUT) + ADDR_WIDTH'(w_out_tag.pixel);
                    r_we      <= 1'b1;
                end
            end
        end
    end

    assign read_address_out  = r_rd_addr;
    assign result_out        = r_result;
    assign write_address_out = r_wr_addr;
    assign we_out            = r_we;
    assign busy              = r_busy;
    assign merge_done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_channel_merge_relu.sv
`default_nettype none
// ============================================================================
// Module      : tb_channel_merge_relu
// Description : Self-checking bench for channel_merge_relu on a 2x2 map, with
//               one instance at read latency 1 and one at read latency 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_merge_relu;

    localparam int MAXC = 8;
    localparam int MAP  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run_s = 1'b0;
    logic        sel = 1'b0;
    logic [3:0]  num_channels = '0;
    logic        relu_en = 1'b0;
    logic [15:0] bias_in = '0;

    logic [15:0] q1, q2a, q2b;
    logic [15:0] ra1, ra2, res1, res2, wa1, wa2;
    logic        we1, we2, busy1, busy2, done1, done2;
    logic        run1, run2;
    logic [15:0] mem [0:31];

    logic [15:0] m_ra, m_res, m_wa;
    logic        m_we, m_busy, m_done;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] wv[$];
    logic [15:0] wa[$];
    int          wc[$];
    logic [15:0] rq[$];
    bit          bq[$];
    int          done_cyc;
    int          nwe_bad;

    always #5 clk = ~clk;

    // Source memory models of latency 1 and 2
    always @(posedge clk) begin
        q1  <= mem[ra1[4:0]];
        q2a <= mem[ra2[4:0]];
        q2b <= q2a;
    end

    assign run1   = run_s & ~sel;
    assign run2   = run_s & sel;
    assign m_ra   = sel ? ra2   : ra1;
    assign m_res  = sel ? res2  : res1;
    assign m_wa   = sel ? wa2   : wa1;
    assign m_we   = sel ? we2   : we1;
    assign m_busy = sel ? busy2 : busy1;
    assign m_done = sel ? done2 : done1;

    channel_merge_relu #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .MAP_WIDTH(2), .MAP_HEIGHT(2),
        .MAX_CHANNELS(MAXC), .READ_LATENCY(1), .BASE_IN(0), .BASE_OUT(0)
    ) dut (
        .clk(clk), .reset(reset), .run(run1), .num_channels(num_channels),
        .relu_en(relu_en), .bias_in(bias_in), .data_in(q1),
        .read_address_out(ra1), .result_out(res1), .write_address_out(wa1),
        .we_out(we1), .busy(busy1), .merge_done(done1)
    );

    channel_merge_relu #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .MAP_WIDTH(2), .MAP_HEIGHT(2),
        .MAX_CHANNELS(MAXC), .READ_LATENCY(2), .BASE_IN(0), .BASE_OUT(0)
    ) dut2 (
        .clk(clk), .reset(reset), .run(run2), .num_channels(num_channels),
        .relu_en(relu_en), .bias_in(bias_in), .data_in(q2b),
        .read_address_out(ra2), .result_out(res2), .write_address_out(wa2),
        .we_out(we2), .busy(busy2), .merge_done(done2)
    );

    // Reference: plain integer sum of the pixel's channels plus bias, clamped
    function automatic logic [15:0] model_pix(input int p, input int c_eff,
                                              input logic relu, input logic [15:0] bias);
        int s;
        s = $signed(bias);
        for (int c = 0; c < c_eff; c++) begin
            s += $signed(mem[c*MAP + p]);
        end
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    endtask

    // Records per-cycle outputs from cycle 1 until merge_done (bounded)
    task automatic capture(input bit pulses);
        wv.delete(); wa.delete(); wc.delete(); rq.delete(); bq.delete();
        done_cyc = -1;
        nwe_bad  = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            run_s = 1'b0;
            rq.push_back(m_ra);
            bq.push_back(m_busy);
            if (m_we) begin
                wv.push_back(m_res);
                wa.push_back(m_wa);
                wc.push_back(cyc);
                if (!m_busy) nwe_bad++;
            end
            if (m_done) begin
                done_cyc = cyc;
                break;
            end
            if (pulses && (cyc == 3 || cyc == 5)) run_s = 1'b1;
        end
        run_s = 1'b0;
    endtask

    task automatic test_merge(input bit s, input logic [3:0] nc, input logic relu,
                              input logic [15:0] bias, input bit pulses,
                              input bit now, input bit b2b, input string name);
        int c_eff, n, lat, rbad, bbad;
        logic [15:0] exp_v;
        c_eff = (nc == 0) ? 1 : ((nc > MAXC) ? MAXC : int'(nc));
        n     = c_eff * MAP;
        lat   = s ? 2 : 1;
        if (!now) @(negedge clk);
        sel = s; num_channels = nc; relu_en = relu; bias_in = bias;
        run_s = 1'b1;
        capture(pulses);

        n_checks++;
        if (done_cyc !== n + 2 + lat) begin
            n_err++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, n + 2 + lat);
        end
        n_checks++;
        if (wv.size() != MAP) begin
            n_err++;
            $display("FAIL %s write_count: got %0d expected %0d", name, wv.size(), MAP);
        end
        for (int p = 0; p < MAP && p < wv.size(); p++) begin
            exp_v = model_pix(p, c_eff, relu, bias);
            n_checks++;
            if (wv[p] !== exp_v) begin
                n_err++;
                $display("FAIL %s result[%0d]: got %h expected %h", name, p, wv[p], exp_v);
            end
            n_checks++;
            if (wa[p] !== 16'(p)) begin
                n_err++;
                $display("FAIL %s waddr[%0d]: got %0d expected %0d", name, p, wa[p], p);
            end
            n_checks++;
            if (wc[p] !== (p + 1) * c_eff + 1 + lat) begin
                n_err++;
                $display("FAIL %s wcycle[%0d]: got %0d expected %0d", name, p, wc[p],
                         (p + 1) * c_eff + 1 + lat);
            end
        end
        rbad = 0;
        for (int k = 0; k < n; k++) begin
            if (k >= rq.size() || rq[k] !== 16'((k % c_eff) * MAP + k / c_eff)) rbad++;
        end
        n_checks++;
        if (rbad != 0) begin
            n_err++;
            $display("FAIL %s read_addr_seq: got %0d bad of %0d expected 0 bad", name, rbad, n);
        end
        bbad = 0;
        for (int cyc = 1; cyc <= n + 2 + lat; cyc++) begin
            if (cyc > bq.size() || bq[cyc-1] !== (cyc <= n + 1 + lat)) bbad++;
        end
        n_checks++;
        if (bbad != 0 || nwe_bad != 0) begin
            n_err++;
            $display("FAIL %s busy_window: got %0d bad busy, %0d we outside busy expected 0",
                     name, bbad, nwe_bad);
        end
        if (!b2b) begin
            @(negedge clk);
            n_checks++;
            if (m_done !== 1'b0 || m_busy !== 1'b0 || m_we !== 1'b0) begin
                n_err++;
                $display("FAIL %s after_done: got done=%b busy=%b we=%b expected 0 0 0",
                         name, m_done, m_busy, m_we);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ra1, res1, wa1, we1, busy1, done1} !== '0) begin
            n_err++;
            $display("FAIL reset_dut1: got ra=%h res=%h wa=%h we=%b busy=%b done=%b expected all 0",
                     ra1, res1, wa1, we1, busy1, done1);
        end
        n_checks++;
        if ({ra2, res2, wa2, we2, busy2, done2} !== '0) begin
            n_err++;
            $display("FAIL reset_dut2: got ra=%h res=%h wa=%h we=%b busy=%b done=%b expected all 0",
                     ra2, res2, wa2, we2, busy2, done2);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_plan_data();
        fill_random();
        mem[0] = 16'd1;  mem[1] = 16'd2;  mem[2] = 16'd3;  mem[3] = 16'd4;
        mem[4] = 16'd10; mem[5] = 16'd20; mem[6] = 16'd30; mem[7] = 16'd40;
    endtask

    task automatic test_two_channel();
        load_plan_data();
        test_merge(1'b0, 4'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, "two_channel");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 32; i++) mem[i] = 16'h7F00;
        test_merge(1'b0, 4'd3, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, "sat_pos");
        for (int i = 0; i < 32; i++) mem[i] = 16'h8000;
        test_merge(1'b0, 4'd3, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, "sat_neg");
    endtask

    task automatic test_relu();
        fill_random();
        mem[0] = 16'd3; mem[1] = 16'd5; mem[2] = 16'd7; mem[3] = 16'hFF9C;
        test_merge(1'b0, 4'd1, 1'b1, 16'hFFFB, 1'b0, 1'b0, 1'b0, "relu");
    endtask

    task automatic test_clamp();
        fill_random();
        test_merge(1'b0, 4'd0, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 1'b0, 1'b0, "nc_zero");
        fill_random();
        test_merge(1'b0, 4'(MAXC + 3), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 1'b0, 1'b0,
                   "nc_over");
    endtask

    task automatic test_ignored_run_and_reset();
        int stray;
        fill_random();
        test_merge(1'b0, 4'd2, 1'b0, 16'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, "run_ignored");
        @(negedge clk);
        sel = 1'b0; num_channels = 4'd2; relu_en = 1'b0; bias_in = 16'd0;
        run_s = 1'b1;
        @(negedge clk);
        run_s = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (m_we !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_we: got %b expected 1", m_we);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({m_ra, m_res, m_wa, m_we, m_busy, m_done} !== '0) begin
            n_err++;
            $display("FAIL abort_clear: got ra=%h res=%h wa=%h we=%b busy=%b done=%b expected all 0",
                     m_ra, m_res, m_wa, m_we, m_busy, m_done);
        end
        stray = 0;
        repeat (2) begin
            @(negedge clk);
            if (m_done || m_we || m_busy) stray++;
        end
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (m_done || m_we || m_busy) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL abort_quiet: got %0d active cycles expected 0", stray);
        end
        test_merge(1'b0, 4'd2, 1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_latency2_back_to_back();
        load_plan_data();
        test_merge(1'b1, 4'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, "lat2_first");
        test_merge(1'b1, 4'd4, 1'b1, 16'($urandom), 1'b0, 1'b1, 1'b0, "lat2_b2b");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            fill_random();
            test_merge(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 1'b0, 1'b0, "random");
        end
    endtask

    initial begin
        fill_random();
        test_reset();
        test_two_channel();
        test_saturation();
        test_relu();
        test_clamp();
        test_ignored_run_and_reset();
        test_latency2_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
